multicycle_ctrl: RTL and testbench
==================================

# multicycle_ctrl

Main control FSM for the multi-cycle MIPS-subset datapath. It sequences the shared ALU, register file, instruction register, PC and unified memory over several clock cycles per instruction. It drives the 3-bit ALUOp consumed by the ALU control decoder, and stalls on a memory ready handshake.

## Interface
Parameters:
- none

Ports:
- clk_i  input  1  system clock; all state changes on rising edge
- rst_i  input  1  asynchronous, active-low reset
- op_i  input  6  opcode field of the instruction register (IR[31:26])
- zero_i  input  1  ALU zero flag
- mem_ready_i  input  1  memory completes the current read/write this cycle
- pc_we_o  output  1  PC write enable
- pc_src_o  output  2  PC source: 00 ALU result, 01 ALUOut register, 10 jump target
- iord_o  output  1  memory address select: 0 PC, 1 ALUOut
- mem_rd_o  output  1  memory read request
- mem_wr_o  output  1  memory write request
- ir_we_o  output  1  instruction register write enable
- reg_dst_o  output  1  write register select: 0 rt, 1 rd
- mem_to_reg_o  output  1  write-back data select: 0 ALUOut, 1 MDR
- reg_we_o  output  1  register file write enable
- alu_src_a_o  output  1  ALU A source: 0 PC, 1 register A
- alu_src_b_o  output  2  ALU B source: 00 register B, 01 constant 4, 10 sign-extended immediate, 11 sign-extended immediate shifted left 2
- alu_op_o  output  3  ALUOp: 100 add, 101 subtract, 010 decode from funct
- instr_done_o  output  1  one-cycle pulse in the final cycle of each instruction
- illegal_o  output  1  one-cycle pulse in DECODE when the opcode is unsupported
- state_o  output  4  current state code, for debug

## Operation
- Opcodes:
  - R-type 000000
  - lw 100011
  - sw 101011
  - beq 000100
  - addi 001000
  - j 000010
- State codes:
  - FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5
  - EXEC 6, RWB 7, BRANCH 8, ADDIEX 9, ADDIWB 10, JUMP 11
- Outputs are Moore-decoded from the state register. Exceptions:
  - pc_we_o in BRANCH follows zero_i.
  - ir_we_o and pc_we_o in FETCH are qualified by mem_ready_i.
- Any output not listed for a state is 0. alu_op_o defaults to 100.
- FETCH:
  - Drives mem_rd=1, iord=0, src_a=0, src_b=01, alu_op=100, pc_src=00.
  - If mem_ready_i: ir_we=1, pc_we=1, next DECODE. Otherwise hold.
- DECODE:
  - Drives src_a=0, src_b=11, alu_op=100, which computes the branch target into ALUOut.
  - Next state by op_i: lw/sw→MEMADR, R→EXEC, beq→BRANCH, addi→ADDIEX, j→JUMP.
  - Any other opcode: illegal_o=1, instr_done_o=1, next FETCH.
- MEMADR: src_a=1, src_b=10, alu_op=100. Next MEMRD for lw, MEMWR for sw.
- MEMRD: mem_rd=1, iord=1. Holds until mem_ready_i, then MEMWB.
- MEMWB: reg_we=1, reg_dst=0, mem_to_reg=1, instr_done=1. Next FETCH.
- MEMWR:
  - Drives mem_wr=1, iord=1.
  - Holds until mem_ready_i, then instr_done=1 and next FETCH.
- EXEC: src_a=1, src_b=00, alu_op=010. Next RWB.
- RWB: reg_we=1, reg_dst=1, mem_to_reg=0, instr_done=1. Next FETCH.
- BRANCH: src_a=1, src_b=00, alu_op=101, pc_src=01, pc_we=zero_i, instr_done=1. Next FETCH.
- ADDIEX: src_a=1, src_b=10, alu_op=100. Next ADDIWB.
- ADDIWB: reg_we=1, reg_dst=0, mem_to_reg=0, instr_done=1. Next FETCH.
- JUMP: pc_src=10, pc_we=1, instr_done=1. Next FETCH.
- Unused codes 12–15: all outputs 0, alu_op=100, next FETCH.

## Timing
- Reset:
  - rst_i low forces state=FETCH immediately (asynchronous).
  - While rst_i is low, pc_we, ir_we, reg_we, mem_rd, mem_wr, instr_done and illegal are gated to 0.
  - While rst_i is low, the remaining outputs show FETCH values: pc_src=00, iord=0, src_a=0, src_b=01, alu_op=100, state_o=0.
- Reset asserted mid-instruction abandons the instruction. No write strobe survives into the reset period.
- Latency with mem_ready_i tied high:
  - lw 5 cycles
  - sw, R-type, addi 4 cycles
  - beq, j 3 cycles
  - illegal opcode 2 cycles
- Each cycle mem_ready_i is low in FETCH, MEMRD or MEMWR adds one cycle. The request outputs and addresses hold stable while waiting.
- mem_ready_i is ignored in every other state.
- op_i is sampled only in DECODE and MEMADR. It must be stable from the cycle after IR write.
- zero_i is sampled only in BRANCH and is used combinationally.
- instr_done_o asserts exactly once per instruction, in its final cycle.

## Test plan
- Reset: hold rst_i=0 with mem_ready_i=1, then release → state_o=0, all strobes 0 during reset; first edge after release gives ir_we=1, pc_we=1, state→1.
- lw with mem_ready_i=1: op 100011 → state sequence 0,1,2,3,4,0. reg_we=1 with mem_to_reg=1 and reg_dst=0 in state 4; instr_done is high only in state 4.
- sw with wait states: op 101011, mem_ready_i low for 3 cycles in MEMWR → mem_wr=1 and iord=1 held for 4 cycles, reg_we never asserted, then return to FETCH.
- R-type then addi: op 000000 gives alu_op=010 in EXEC and reg_dst=1 in RWB; op 001000 gives alu_op=100 with src_b=10 in ADDIEX and reg_dst=0 in ADDIWB.
- beq: zero_i=1 → pc_we=1, pc_src=01, alu_op=101 in state 8. zero_i=0 → pc_we=0. j gives pc_src=10, pc_we=1 in state 11.
- Illegal opcode 111111 → illegal_o pulse in DECODE, next FETCH. Assert rst_i low during MEMRD → state_o=0 immediately and mem_rd gated off.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - main control FSM for the multi-cycle MIPS-subset datapath
// Moore-decoded controller; write/request strobes are gated off while rst_i is low.
module multicycle_ctrl (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [5:0] op_i,
  input  logic       zero_i,
  input  logic       mem_ready_i,
  output logic       pc_we_o,
  output logic [1:0] pc_src_o,
  output logic       iord_o,
  output logic       mem_rd_o,
  output logic       mem_wr_o,
  output logic       ir_we_o,
  output logic       reg_dst_o,
  output logic       mem_to_reg_o,
  output logic       reg_we_o,
  output logic       alu_src_a_o,
  output logic [1:0] alu_src_b_o,
  output logic [2:0] alu_op_o,
  output logic       instr_done_o,
  output logic       illegal_o,
  output logic [3:0] state_o
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,  S_DECODE = 4'd1,  S_MEMADR = 4'd2,  S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,  S_MEMWR  = 4'd5,  S_EXEC   = 4'd6,  S_RWB    = 4'd7,
    S_BRANCH = 4'd8,  S_ADDIEX = 4'd9,  S_ADDIWB = 4'd10, S_JUMP   = 4'd11
  } state_t;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;

  state_t state_q, state_d;
  logic   pc_we_raw, mem_rd_raw, mem_wr_raw, ir_we_raw, reg_we_raw, done_raw, illegal_raw;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d      = state_q;
    pc_we_raw    = 1'b0;
    pc_src_o     = 2'b00;
    iord_o       = 1'b0;
    mem_rd_raw   = 1'b0;
    mem_wr_raw   = 1'b0;
    ir_we_raw    = 1'b0;
    reg_dst_o    = 1'b0;
    mem_to_reg_o = 1'b0;
    reg_we_raw   = 1'b0;
    alu_src_a_o  = 1'b0;
    alu_src_b_o  = 2'b00;
    alu_op_o     = 3'b100;
    done_raw     = 1'b0;
    illegal_raw  = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_rd_raw  = 1'b1;
        alu_src_b_o = 2'b01;
        if (mem_ready_i) begin
          ir_we_raw = 1'b1;
          pc_we_raw = 1'b1;
          state_d   = S_DECODE;
        end
      end
      S_DECODE: begin
        // Branch target is computed speculatively into ALUOut here.
        alu_src_b_o = 2'b11;
        case (op_i)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXEC;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JUMP;
          default: begin
            illegal_raw = 1'b1;
            done_raw    = 1'b1;
            state_d     = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        alu_src_a_o = 1'b1;
        alu_src_b_o = 2'b10;
        state_d     = (op_i == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        mem_rd_raw = 1'b1;
        iord_o     = 1'b1;
        if (mem_ready_i) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        reg_we_raw   = 1'b1;
        mem_to_reg_o = 1'b1;
        done_raw     = 1'b1;
        state_d      = S_FETCH;
      end
      S_MEMWR: begin
        mem_wr_raw = 1'b1;
        iord_o     = 1'b1;
        if (mem_ready_i) begin
          done_raw = 1'b1;
          state_d  = S_FETCH;
        end
      end
      S_EXEC: begin
        alu_src_a_o = 1'b1;
        alu_op_o    = 3'b010;
        state_d     = S_RWB;
      end
      S_RWB: begin
        reg_we_raw = 1'b1;
        reg_dst_o  = 1'b1;
        done_raw   = 1'b1;
        state_d    = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a_o = 1'b1;
        alu_op_o    = 3'b101;
        pc_src_o    = 2'b01;
        pc_we_raw   = zero_i;
        done_raw    = 1'b1;
        state_d     = S_FETCH;
      end
      S_ADDIEX: begin
        alu_src_a_o = 1'b1;
        alu_src_b_o = 2'b10;
        state_d     = S_ADDIWB;
      end
      S_ADDIWB: begin
        reg_we_raw = 1'b1;
        done_raw   = 1'b1;
        state_d    = S_FETCH;
      end
      S_JUMP: begin
        pc_src_o  = 2'b10;
        pc_we_raw = 1'b1;
        done_raw  = 1'b1;
        state_d   = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
  end

  assign pc_we_o      = pc_we_raw   & rst_i;
  assign mem_rd_o     = mem_rd_raw  & rst_i;
  assign mem_wr_o     = mem_wr_raw  & rst_i;
  assign ir_we_o      = ir_we_raw   & rst_i;
  assign reg_we_o     = reg_we_raw  & rst_i;
  assign instr_done_o = done_raw    & rst_i;
  assign illegal_o    = illegal_raw & rst_i;
  assign state_o      = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - scoreboard bench for multicycle_ctrl
// Driver expands each instruction into its expected per-cycle trace; monitor compares at negedge.
module tb_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       rst_i = 1'b0;
  logic [5:0] op_i = 6'd0;
  logic       zero_i = 1'b0;
  logic       mem_ready_i = 1'b0;
  logic       pc_we_o, iord_o, mem_rd_o, mem_wr_o, ir_we_o, reg_dst_o, mem_to_reg_o;
  logic       reg_we_o, alu_src_a_o, instr_done_o, illegal_o;
  logic [1:0] pc_src_o, alu_src_b_o;
  logic [2:0] alu_op_o;
  logic [3:0] state_o;

  int checks = 0;
  int errors = 0;
  logic [21:0] exp_q[$];

  always #5 clk = ~clk;

  multicycle_ctrl dut (
    .clk_i(clk), .rst_i(rst_i), .op_i(op_i), .zero_i(zero_i), .mem_ready_i(mem_ready_i),
    .pc_we_o(pc_we_o), .pc_src_o(pc_src_o), .iord_o(iord_o), .mem_rd_o(mem_rd_o),
    .mem_wr_o(mem_wr_o), .ir_we_o(ir_we_o), .reg_dst_o(reg_dst_o),
    .mem_to_reg_o(mem_to_reg_o), .reg_we_o(reg_we_o), .alu_src_a_o(alu_src_a_o),
    .alu_src_b_o(alu_src_b_o), .alu_op_o(alu_op_o), .instr_done_o(instr_done_o),
    .illegal_o(illegal_o), .state_o(state_o)
  );

  function automatic logic is_legal(input logic [5:0] op);
    return op inside {6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b001000, 6'b000010};
  endfunction

  // Expected outputs for one cycle, from the per-state description of the controller.
  function automatic logic [21:0] exp_vec(input int st, input logic rst, input logic rdy,
                                          input logic z, input logic [5:0] op);
    logic       pc_we = 0, iord = 0, mem_rd = 0, mem_wr = 0, ir_we = 0, reg_dst = 0;
    logic       m2r = 0, reg_we = 0, src_a = 0, done = 0, ill = 0;
    logic [1:0] pc_src = 2'b00, src_b = 2'b00;
    logic [2:0] alu = 3'b100;
    logic [3:0] s = st[3:0];
    case (st)
      0:  begin mem_rd = 1; src_b = 2'b01; pc_we = rdy; ir_we = rdy; end
      1:  begin src_b = 2'b11; ill = !is_legal(op); done = !is_legal(op); end
      2:  begin src_a = 1; src_b = 2'b10; end
      3:  begin mem_rd = 1; iord = 1; end
      4:  begin reg_we = 1; m2r = 1; done = 1; end
      5:  begin mem_wr = 1; iord = 1; done = rdy; end
      6:  begin src_a = 1; alu = 3'b010; end
      7:  begin reg_we = 1; reg_dst = 1; done = 1; end
      8:  begin src_a = 1; alu = 3'b101; pc_src = 2'b01; pc_we = z; done = 1; end
      9:  begin src_a = 1; src_b = 2'b10; end
      10: begin reg_we = 1; done = 1; end
      11: begin pc_src = 2'b10; pc_we = 1; done = 1; end
      default: ;
    endcase
    if (!rst) begin
      {pc_we, ir_we, reg_we, mem_rd, mem_wr, done, ill} = '0;
    end
    return {s, pc_we, pc_src, iord, mem_rd, mem_wr, ir_we, reg_dst, m2r, reg_we,
            src_a, src_b, alu, done, ill};
  endfunction

  task automatic cyc(input int st, input logic rst, input logic rdy, input logic z,
                     input logic [5:0] op);
    rst_i = rst;
    mem_ready_i = rdy;
    zero_i = z;
    op_i = op;
    exp_q.push_back(exp_vec(st, rst, rdy, z, op));
    @(posedge clk);
    #1;
  endtask

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic do_fetch(input int fw);
    for (int i = 0; i < fw; i++) cyc(0, 1, 0, rb(), 6'($urandom));
    cyc(0, 1, 1, rb(), 6'($urandom));
  endtask

  task automatic run_instr(input logic [5:0] op, input int fw, input int mw, input logic bz);
    do_fetch(fw);
    cyc(1, 1, rb(), rb(), op);
    if (is_legal(op)) begin
      case (op)
        6'b100011: begin
          cyc(2, 1, rb(), rb(), op);
          for (int i = 0; i < mw; i++) cyc(3, 1, 0, rb(), op);
          cyc(3, 1, 1, rb(), op);
          cyc(4, 1, rb(), rb(), op);
        end
        6'b101011: begin
          cyc(2, 1, rb(), rb(), op);
          for (int i = 0; i < mw; i++) cyc(5, 1, 0, rb(), op);
          cyc(5, 1, 1, rb(), op);
        end
        6'b000000: begin cyc(6, 1, rb(), rb(), op); cyc(7, 1, rb(), rb(), op); end
        6'b001000: begin cyc(9, 1, rb(), rb(), op); cyc(10, 1, rb(), rb(), op); end
        6'b000100: cyc(8, 1, rb(), bz, op);
        default:   cyc(11, 1, rb(), rb(), op);
      endcase
    end
  endtask

  always @(negedge clk) begin
    logic [21:0] e, a;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      a = {state_o, pc_we_o, pc_src_o, iord_o, mem_rd_o, mem_wr_o, ir_we_o, reg_dst_o,
           mem_to_reg_o, reg_we_o, alu_src_a_o, alu_src_b_o, alu_op_o, instr_done_o, illegal_o};
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL cycle_outputs t=%0t state=%0d actual=%h expected=%h", $time, e[21:18], a, e);
      end
    end
  end

  logic [5:0] ops[7] = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b001000, 6'b000010, 6'b111111};

  initial begin
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) cyc(0, 0, 1, rb(), 6'($urandom));
    run_instr(6'b100011, 0, 0, 0);
    run_instr(6'b101011, 0, 3, 0);
    run_instr(6'b000000, 0, 0, 0);
    run_instr(6'b001000, 0, 0, 0);
    run_instr(6'b000100, 0, 0, 1);
    run_instr(6'b000100, 0, 0, 0);
    run_instr(6'b000010, 0, 0, 0);
    run_instr(6'b111111, 0, 0, 0);
    // Reset asserted while the lw sits in MEMRD waiting for memory.
    do_fetch(1);
    cyc(1, 1, 1, 0, 6'b100011);
    cyc(2, 1, 1, 0, 6'b100011);
    cyc(3, 1, 0, 0, 6'b100011);
    cyc(0, 0, 1, 0, 6'b100011);
    cyc(0, 0, 0, 1, 6'b100011);
    run_instr(6'b100011, 2, 2, 0);
    for (int n = 0; n < 150; n++) begin
      logic [5:0] op;
      op = ($urandom_range(0, 9) == 0) ? 6'($urandom) : ops[$urandom_range(0, 6)];
      run_instr(op, $urandom_range(0, 2), $urandom_range(0, 3), rb());
    end
    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain actual=%0d pending expected=0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
